// File: rtl/tt_um_nithin574.sv
// Tiny Tapeout 8-bit accumulator ALU: one opcode per clock, ACC on uo_out, flags Z/C/N/V on uio_out[7:4].
// Optional build macro ALU_SATURATE_EN makes ADD/SUB saturate unsigned instead of wrapping.
module tt_um_nithin574 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_LOAD = 4'h1, OP_ADD = 4'h2, OP_SUB  = 4'h3,
        OP_AND  = 4'h4, OP_OR   = 4'h5, OP_XOR = 4'h6, OP_SHL  = 4'h7,
        OP_SHR  = 4'h8, OP_ROL  = 4'h9, OP_ROR = 4'hA, OP_INC  = 4'hB,
        OP_DEC  = 4'hC, OP_NOT  = 4'hD, OP_CLR = 4'hE, OP_SWAP = 4'hF
    } op_t;

    // Signed overflow: operands share a sign that the result does not.
    function automatic logic add_ovf(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r);
        return (a[7] == b[7]) && (r[7] != a[7]);
    endfunction

    function automatic logic sub_ovf(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r);
        return (a[7] != b[7]) && (r[7] != a[7]);
    endfunction

    logic [7:0] acc_r, acc_nxt_s;
    logic       z_r, c_r, n_r, v_r;
    logic       z_nxt_s, c_nxt_s, n_nxt_s, v_nxt_s;
    logic       upd_s;
    logic [8:0] sum_s, diff_s;
    logic [7:0] inc_s, dec_s;
    op_t        op_s;
    logic       unused_s;

    assign op_s     = op_t'(uio_in[3:0]);
    assign sum_s    = {1'b0, acc_r} + {1'b0, ui_in};
    assign diff_s   = {1'b0, acc_r} - {1'b0, ui_in};
    assign inc_s    = acc_r + 8'h01;
    assign dec_s    = acc_r - 8'h01;
    assign unused_s = &{1'b0, ena, uio_in[7:4]};

    // Next-state ALU: result, carry and overflow per opcode; Z/N follow the new ACC.
    always_comb begin
        acc_nxt_s = acc_r;
        c_nxt_s   = c_r;
        v_nxt_s   = 1'b0;
        upd_s     = 1'b1;
        case (op_s)
            OP_NOP: begin
                upd_s   = 1'b0;
                v_nxt_s = v_r;
            end
            OP_LOAD: acc_nxt_s = ui_in;
            OP_ADD: begin
                c_nxt_s = sum_s[8];
                v_nxt_s = add_ovf(acc_r, ui_in, sum_s[7:0]);
`ifdef ALU_SATURATE_EN
                if (sum_s[8]) acc_nxt_s = 8'hFF;
                else          acc_nxt_s = sum_s[7:0];
`else
                acc_nxt_s = sum_s[7:0];
`endif
            end
            OP_SUB: begin
                c_nxt_s = diff_s[8];
                v_nxt_s = sub_ovf(acc_r, ui_in, diff_s[7:0]);
`ifdef ALU_SATURATE_EN
                if (diff_s[8]) acc_nxt_s = 8'h00;
                else           acc_nxt_s = diff_s[7:0];
`else
                acc_nxt_s = diff_s[7:0];
`endif
            end
            OP_AND: acc_nxt_s = acc_r & ui_in;
            OP_OR:  acc_nxt_s = acc_r | ui_in;
            OP_XOR: acc_nxt_s = acc_r ^ ui_in;
            OP_SHL: begin
                acc_nxt_s = {acc_r[6:0], 1'b0};
                c_nxt_s   = acc_r[7];
            end
            OP_SHR: begin
                acc_nxt_s = {1'b0, acc_r[7:1]};
                c_nxt_s   = acc_r[0];
            end
            OP_ROL: begin
                acc_nxt_s = {acc_r[6:0], acc_r[7]};
                c_nxt_s   = acc_r[7];
            end
            OP_ROR: begin
                acc_nxt_s = {acc_r[0], acc_r[7:1]};
                c_nxt_s   = acc_r[0];
            end
            OP_INC: begin
                acc_nxt_s = inc_s;
                c_nxt_s   = (acc_r == 8'hFF);
                v_nxt_s   = add_ovf(acc_r, 8'h01, inc_s);
            end
            OP_DEC: begin
                acc_nxt_s = dec_s;
                c_nxt_s   = (acc_r == 8'h00);
                v_nxt_s   = sub_ovf(acc_r, 8'h01, dec_s);
            end
            OP_NOT: acc_nxt_s = ~acc_r;
            OP_CLR: begin
                acc_nxt_s = 8'h00;
                c_nxt_s   = 1'b0;
            end
            OP_SWAP: acc_nxt_s = {acc_r[3:0], acc_r[7:4]};
            default: begin
                upd_s   = 1'b0;
                v_nxt_s = v_r;
            end
        endcase
        if (upd_s) begin
            z_nxt_s = (acc_nxt_s == 8'h00);
            n_nxt_s = acc_nxt_s[7];
        end else begin
            z_nxt_s = z_r;
            n_nxt_s = n_r;
        end
    end

    // Accumulator and flag registers; reset input is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc_r <= 8'h00;
            z_r   <= 1'b1;
            c_r   <= 1'b0;
            n_r   <= 1'b0;
            v_r   <= 1'b0;
        end else begin
            acc_r <= acc_nxt_s;
            z_r   <= z_nxt_s;
            c_r   <= c_nxt_s;
            n_r   <= n_nxt_s;
            v_r   <= v_nxt_s;
        end
    end

    assign uo_out  = acc_r;
    assign uio_out = {v_r, n_r, c_r, z_r, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_nithin574.sv
// Self-checking bench for tt_um_nithin574: directed plan sequence plus randomized ops against an integer reference model.
module tb_tt_um_nithin574;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp;
    int n_err;

    int m_acc;
    bit m_z, m_c, m_n, m_v;

    tt_um_nithin574 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp_v);
        end
    endtask

    function automatic int sgn(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_z = 1; m_c = 0; m_n = 0; m_v = 0;
    endtask

    // Reference behaviour from the opcode table, in plain integer arithmetic.
    task automatic model_op(input int op, input int b);
        int r;
        int sr;
        if (op == 0) return;
        r   = m_acc;
        m_v = 0;
        case (op)
            1: r = b;
            2: begin
                r   = m_acc + b;
                m_c = (r > 255);
                sr  = sgn(m_acc) + sgn(b);
                m_v = (sr > 127) || (sr < -128);
`ifdef ALU_SATURATE_EN
                if (r > 255) r = 255;
`endif
                r = r % 256;
            end
            3: begin
                r   = m_acc - b;
                m_c = (r < 0);
                sr  = sgn(m_acc) - sgn(b);
                m_v = (sr > 127) || (sr < -128);
`ifdef ALU_SATURATE_EN
                if (r < 0) r = 0;
`endif
                r = (r + 256) % 256;
            end
            4: r = m_acc & b;
            5: r = m_acc | b;
            6: r = m_acc ^ b;
            7: begin m_c = (m_acc >= 128); r = (m_acc * 2) % 256; end
            8: begin m_c = (m_acc % 2 == 1); r = m_acc / 2; end
            9: begin m_c = (m_acc >= 128); r = (m_acc * 2) % 256 + m_acc / 128; end
            10: begin m_c = (m_acc % 2 == 1); r = m_acc / 2 + (m_acc % 2) * 128; end
            11: begin m_c = (m_acc == 255); m_v = (sgn(m_acc) + 1 > 127); r = (m_acc + 1) % 256; end
            12: begin m_c = (m_acc == 0); m_v = (sgn(m_acc) - 1 < -128); r = (m_acc + 255) % 256; end
            13: r = 255 - m_acc;
            14: begin r = 0; m_c = 0; end
            15: r = (m_acc % 16) * 16 + m_acc / 16;
            default: r = m_acc;
        endcase
        m_acc = r;
        m_z   = (r == 0);
        m_n   = (r >= 128);
    endtask

    function automatic logic [7:0] exp_flags();
        return {m_v, m_n, m_c, m_z, 4'b0000};
    endfunction

    // One operation: drive, clock, update model, compare both output buses.
    task automatic step(input string tag, input int op, input int b);
        logic [7:0] opb;
        logic [7:0] bb;
        opb    = 8'(op);
        bb     = 8'(b);
        uio_in = {4'($urandom_range(15)), opb[3:0]};
        ui_in  = bb;
        ena    = 1'($urandom_range(1));
        @(posedge clk);
        #1;
        model_op(op, b);
        check({tag, ".acc"}, uo_out, 8'(m_acc));
        check({tag, ".flags"}, uio_out, exp_flags());
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h01;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset.acc", uo_out, 8'h00);
        check("reset.flags", uio_out, 8'h10);
        check("reset.oe", uio_oe, 8'hF0);
        rst_n = 1'b0;

        // LOAD and hold
        step("load1", 1, 8'h01);
        step("load1b", 1, 8'h01);
        step("nop", 0, 8'h55);
        check("nop.plan", uo_out, 8'h01);
        // ADD overflow and carry
        step("ld7f", 1, 8'h7F);
        step("add80", 2, 8'h01);
        check("add80.plan", uio_out, 8'hC0);
        step("ldff", 1, 8'hFF);
        step("addff", 2, 8'h01);
        step("ld05", 1, 8'h05);
        step("sub07", 3, 8'h07);
        // shifts / rotates / swap
        step("ld81", 1, 8'h81);
        step("rol", 9, 0);
        check("rol.plan", uo_out, 8'h03);
        step("ror", 10, 0);
        step("shr", 8, 0);
        check("shr.plan", uo_out, 8'h40);
        step("shl", 7, 0);
        step("lda5", 1, 8'hA5);
        step("swap", 15, 0);
        check("swap.plan", uo_out, 8'h5A);
        // logic / INC / DEC
        step("ldf0", 1, 8'hF0);
        step("xor", 6, 8'hFF);
        step("not", 13, 0);
        step("and", 4, 8'h3C);
        step("or", 5, 8'h81);
        step("clr", 14, 0);
        step("dec", 12, 0);
        check("dec.plan", uio_out, 8'h60);
        step("inc", 11, 0);
        check("inc.plan", uio_out, 8'h30);
        step("ld80", 1, 8'h80);
        step("dec80", 12, 0);

        // Asynchronous reset between edges, pending LOAD discarded
        step("ld33", 1, 8'h33);
        #2 rst_n = 1'b1;
        #1;
        model_reset();
        check("async.acc", uo_out, 8'h00);
        check("async.flags", uio_out, 8'h10);
        uio_in = 8'h01;
        ui_in  = 8'hAA;
        @(posedge clk);
        #1;
        check("held.acc", uo_out, 8'h00);
        rst_n = 1'b0;
        step("post", 0, 8'hAA);

        // Randomized ops with occasional mid-cycle reset
        for (int i = 0; i < 600; i++) begin
            step("rnd", int'($urandom_range(15)), int'($urandom_range(255)));
            if ($urandom_range(63) == 0) begin
                #2 rst_n = 1'b1;
                #1;
                model_reset();
                check("rnd.rst.acc", uo_out, 8'h00);
                check("rnd.rst.flags", uio_out, 8'h10);
                rst_n = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tt_um_nithin574.md
Name: tt_um_nithin574

Overview:
- Tiny Tapeout user tile: 8-bit accumulator ALU; one operation per clock.
- Operand on ui_in, 4-bit opcode on uio_in[3:0]; accumulator on uo_out, status flags on uio_out[7:4].
- Sits directly under the TT harness; no submodules required.

Parameters:
- None. Widths fixed by the TT pinout: 8-bit data, 4-bit opcode, 4 flags.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-high reset (asserted when 1 despite the name); clears all state immediately.
- ena  input  1  harness enable; ignored by the logic (may be X); no state depends on it.
- ui_in  input  8  operand B.
- uio_in  input  8  [3:0] opcode; [7:4] unused.
- uo_out  output  8  accumulator ACC, driven directly from the register.
- uio_out  output  8  [3:0]=0; [4]=Z; [5]=C; [6]=N; [7]=V.
- uio_oe  output  8  constant 8'hF0.

Behaviour:
- State: ACC[7:0], flags Z,C,N,V. All are registered; outputs have no combinational path from inputs.
- Reset (rst_n=1, asynchronous): ACC=0, C=0, V=0, N=0, Z=1. So uo_out=0x00 and uio_out=0x10 while reset is held. Reset mid-operation discards the pending op.
- Each rising edge with rst_n=0, execute the opcode. Result and flags appear 1 cycle later (1-cycle latency).
- Opcodes (B=ui_in), with C behaviour:
  - 0 NOP: hold ACC and all flags.
  - 1 LOAD: ACC=B; C unchanged.
  - 2 ADD: ACC=ACC+B; C=carry out of bit 7.
  - 3 SUB: ACC=ACC-B; C=borrow, i.e. 1 when ACC<B unsigned.
  - 4 AND, 5 OR, 6 XOR (ACC op B): C unchanged.
  - 7 SHL: ACC<<1, bit0=0; C=old bit7.
  - 8 SHR: logical shift right, bit7=0; C=old bit0.
  - 9 ROL: rotate left; C=old bit7.
  - A ROR: rotate right; C=old bit0.
  - B INC: ACC+1; C=1 on 0xFF->0x00.
  - C DEC: ACC-1; C=1 on 0x00->0xFF.
  - D NOT: ~ACC; C unchanged.
  - E CLR: ACC=0; C=0.
  - F SWAP: exchange nibbles; C unchanged.
- V (signed overflow):
  - Computed for ADD, SUB, INC, DEC.
  - Cleared for all other ops except NOP, which holds it.
- Z and N:
  - Z=(new ACC==0), N=new ACC[7]; updated on every op except NOP.
- Arithmetic wraps modulo 256 (unless the optional feature is compiled in).
- Unused inputs uio_in[7:4] have no effect.

Optional Feature:
- Macro ALU_SATURATE_EN.
- Defined: ADD and SUB saturate unsigned.
  - ADD overflow gives ACC=0xFF, C=1.
  - SUB underflow gives ACC=0x00, C=1.
  - V is computed from the unsaturated result.
  - INC/DEC still wrap.
- Undefined: all arithmetic wraps modulo 256 as above.

Test Plan:
- Reset: hold rst_n=1, toggle clk -> uo_out=0x00, uio_out=0x10, uio_oe=0xF0. Assert rst_n between edges -> outputs clear without waiting for an edge.
- LOAD/hold: rst_n=0, uio_in=0x01, ui_in=0x01 -> uo_out=0x01 after the next edge, Z=0. Keep applying every cycle -> stays 0x01. Then opcode 0 with ui_in=0x55 -> ACC stays 0x01.
- ADD carry/overflow:
  - LOAD 0x7F, ADD 0x01 -> ACC=0x80, V=1, N=1, C=0.
  - LOAD 0xFF, ADD 0x01 -> ACC=0x00, Z=1, C=1 (saturating build: ACC=0xFF, C=1).
- SUB borrow: LOAD 0x05, SUB 0x07 -> ACC=0xFE, C=1, N=1 (saturating build: 0x00).
- Shifts/rotates:
  - LOAD 0x81, ROL -> 0x03, C=1.
  - ROR -> 0x81, C=1.
  - SHR -> 0x40, C=1.
  - SWAP on 0xA5 -> 0x5A.
- Logic/INC/DEC:
  - LOAD 0xF0, XOR 0xFF -> 0x0F.
  - NOT -> 0xF0.
  - CLR -> 0x00, Z=1.
  - DEC -> 0xFF, C=1.
  - INC -> 0x00, C=1, Z=1.
